// File: rtl/spi_master_if.sv
// Bus bundle for spi_master: request/response handshake toward the fabric
// plus the four SPI wires, with a debug view of the controller state.
interface spi_master_if #(
  parameter int WIDTH = 8
);
  // Request/response handshake:
  //   START is a one-cycle request that is accepted on any rising CLK edge
  //   where BUSY is low; TX_DATA is captured on that same edge. BUSY stays
  //   high until the edge that raises DONE. DONE is high for exactly one
  //   cycle, and RX_DATA holds the received word from that edge onward.
  //   A START seen while BUSY is high is dropped, not queued.
  logic             START;
  logic [WIDTH-1:0] TX_DATA;
  logic [WIDTH-1:0] RX_DATA;
  logic             BUSY;
  logic             DONE;
  // SPI mode-0 wires
  logic             SCLK;
  logic             MOSI;
  logic             MISO;
  logic             CS;
  // Controller state encoding, exposed for observation only
  logic [2:0]       dbg_state;

  modport master (
    input  START, TX_DATA, MISO,
    output RX_DATA, BUSY, DONE, SCLK, MOSI, CS, dbg_state
  );

  modport slave (
    output START, TX_DATA, MISO,
    input  RX_DATA, BUSY, DONE, SCLK, MOSI, CS, dbg_state
  );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 initiator: one START request becomes a CS-framed transfer of
// WIDTH bits, MSB first, with each SCLK phase lasting CLK_DIV system clocks.
// The word shifted in on MISO is returned with a one-cycle DONE strobe.
module spi_master #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 2
) (
  input  logic          CLK,
  input  logic          RST_N,
  spi_master_if.master  bus
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEAD   = 3'd1,
    ST_HIGH   = 3'd2,
    ST_LOW    = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]   tx_sh_q, tx_sh_d;
  logic [WIDTH-1:0]   rx_sh_q, rx_sh_d;
  logic [WIDTH-1:0]   rx_data_q, rx_data_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic               cs_q, cs_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Helpers: MISO appended below the RX register, TX register shifted by one,
  // and "this edge ends the current half-period".
  logic [WIDTH:0]     rx_ext;
  logic [WIDTH-1:0]   tx_shift;
  logic               half_done;

  // State and datapath registers; reset aborts any transfer in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_q      <= cs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state and output logic. Every registered output changes only on the
  // edge that ends a half-period, so each SCLK phase is exactly CLK_DIV long.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_d      = cs_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rx_ext    = {rx_sh_q, bus.MISO};
    tx_shift  = tx_sh_q << 1;
    half_done = (div_cnt_q == DIV_LAST);

    case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          tx_sh_d   = bus.TX_DATA;
          rx_sh_d   = '0;
          mosi_d    = bus.TX_DATA[WIDTH-1];
          cs_d      = 1'b0;
          busy_d    = 1'b1;
          sclk_d    = 1'b0;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = ST_LEAD;
        end
      end

      ST_LEAD, ST_LOW: begin
        if (half_done) begin
          // Rising SCLK: sample MISO, which was set up during the low phase
          div_cnt_d = '0;
          sclk_d    = 1'b1;
          rx_sh_d   = rx_ext[WIDTH-1:0];
          state_d   = ST_HIGH;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      ST_HIGH: begin
        if (half_done) begin
          // Falling SCLK: either present the next bit or hold for the CS tail
          div_cnt_d = '0;
          sclk_d    = 1'b0;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_LAST) begin
            state_d = ST_FINISH;
          end else begin
            tx_sh_d = tx_shift;
            mosi_d  = tx_shift[WIDTH-1];
            state_d = ST_LOW;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      ST_FINISH: begin
        if (half_done) begin
          div_cnt_d = '0;
          cs_d      = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
          mosi_d    = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.RX_DATA   = rx_data_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.SCLK      = sclk_q;
  assign bus.MOSI      = mosi_q;
  assign bus.CS        = cs_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a default-size instance (WIDTH=8, CLK_DIV=2) with a
// selectable loopback or shift-out responder on MISO, and a WIDTH=16,
// CLK_DIV=1 instance in permanent loopback.
module tb_spi_master;

  logic CLK;
  logic RST_N;

  int total = 0;
  int bad   = 0;

  spi_master_if #(.WIDTH(8))  bus0 ();
  spi_master_if #(.WIDTH(16)) bus1 ();

  spi_master #(.WIDTH(8), .CLK_DIV(2)) u_dut0 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus0)
  );

  spi_master #(.WIDTH(16), .CLK_DIV(1)) u_dut1 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus1)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- MISO sources ----------------
  bit         loop_en;
  logic [7:0] resp_word;
  logic [7:0] resp_sh;

  // Responder: MSB preset when CS falls, next bit on each SCLK falling edge
  always @(negedge bus0.CS) resp_sh = resp_word;
  always @(negedge bus0.SCLK) if (bus0.CS == 1'b0) resp_sh = resp_sh << 1;

  assign bus0.MISO = loop_en ? bus0.MOSI : resp_sh[7];
  assign bus1.MISO = bus1.MOSI;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic g_sclk(input int sel); return sel ? bus1.SCLK : bus0.SCLK; endfunction
  function automatic logic g_cs  (input int sel); return sel ? bus1.CS   : bus0.CS;   endfunction
  function automatic logic g_mosi(input int sel); return sel ? bus1.MOSI : bus0.MOSI; endfunction
  function automatic logic g_done(input int sel); return sel ? bus1.DONE : bus0.DONE; endfunction
  function automatic logic g_busy(input int sel); return sel ? bus1.BUSY : bus0.BUSY; endfunction
  function automatic logic [15:0] g_rx(input int sel);
    return sel ? bus1.RX_DATA : {8'h00, bus0.RX_DATA};
  endfunction

  task automatic set_in(input int sel, input logic start, input logic [15:0] tx);
    if (sel != 0) begin
      bus1.START   = start;
      bus1.TX_DATA = tx;
    end else begin
      bus0.START   = start;
      bus0.TX_DATA = tx[7:0];
    end
  endtask

  // ---------------- driver: one START pulse and full observation ----------------
  // repulse_at: cycle after e0 at which START is pulsed again with ~tx (0 = never)
  // rst_at:     cycle after e0 at which RST_N is asserted (0 = never)
  task automatic run_xfer(input int sel, input logic [15:0] tx,
                          input int repulse_at, input int rst_at,
                          output int lat, output int rises,
                          output bit mosi_ok, output bit timing_ok);
    int  w, h, n;
    bit  prev_sclk, stop;
    w = (sel != 0) ? 16 : 8;
    h = (sel != 0) ? 1 : 2;
    lat = -1; rises = 0; mosi_ok = 1; timing_ok = 1; stop = 0;
    @(negedge CLK);
    set_in(sel, 1'b1, tx);
    @(posedge CLK);                 // acceptance edge e0
    @(negedge CLK);
    set_in(sel, 1'b0, ~tx);         // later TX_DATA changes must not matter
    check("accept_busy", g_busy(sel), 1'b1);
    check("accept_cs", g_cs(sel), 1'b0);
    check("accept_mosi_msb", g_mosi(sel), tx[w-1]);
    prev_sclk = g_sclk(sel);
    n = 0;
    while (!stop && n < 200) begin
      @(negedge CLK);
      n++;
      if (rst_at != 0 && n == rst_at) begin
        RST_N = 1'b0;
        #1;
        check("rst_cs", g_cs(sel), 1'b1);
        check("rst_sclk", g_sclk(sel), 1'b0);
        check("rst_mosi", g_mosi(sel), 1'b0);
        check("rst_busy", g_busy(sel), 1'b0);
        check("rst_rx", g_rx(sel), 16'h0000);
        check("rst_state", bus0.dbg_state, 3'd0);
        for (int c = 0; c < 3; c++) begin
          @(negedge CLK);
          check("rst_no_done", g_done(sel), 1'b0);
        end
        RST_N = 1'b1;
        stop = 1;
      end else begin
        if (g_sclk(sel) && !prev_sclk) begin
          if (g_cs(sel) == 1'b0) begin
            if (n != (2 * rises + 1) * h) timing_ok = 0;
            if (g_mosi(sel) !== tx[w-1-rises]) mosi_ok = 0;
            rises++;
          end
        end
        if (g_sclk(sel) && g_cs(sel)) timing_ok = 0;
        prev_sclk = g_sclk(sel);
        if (repulse_at != 0 && n == repulse_at)     set_in(sel, 1'b1, ~tx);
        if (repulse_at != 0 && n == repulse_at + 1) set_in(sel, 1'b0, tx);
        if (g_done(sel)) begin
          lat  = n;
          stop = 1;
          check("done_busy_low", g_busy(sel), 1'b0);
          check("done_cs_high", g_cs(sel), 1'b1);
          check("done_mosi_low", g_mosi(sel), 1'b0);
          @(negedge CLK);
          check("done_one_cycle", g_done(sel), 1'b0);
        end
      end
    end
    if (!stop) check("xfer_timeout", 0, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] tx;
    bit         loop;
    logic [7:0] resp;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int   lat, rises;
    bit   mosi_ok, timing_ok, found;
    logic [7:0] words[3];

    vecs[0] = '{tx: 8'hA5, loop: 1, resp: 8'h00, exp_rx: 8'hA5};
    vecs[1] = '{tx: 8'hFF, loop: 0, resp: 8'h3C, exp_rx: 8'h3C};
    vecs[2] = '{tx: 8'h00, loop: 1, resp: 8'h00, exp_rx: 8'h00};
    vecs[3] = '{tx: 8'h5A, loop: 0, resp: 8'hC3, exp_rx: 8'hC3};
    vecs[4] = '{tx: 8'h81, loop: 1, resp: 8'h00, exp_rx: 8'h81};
    words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'h55;

    // ---- reset ----
    RST_N = 1'b0;
    loop_en = 1; resp_word = 8'h00; resp_sh = 8'h00;
    set_in(0, 1'b0, 16'h0000);
    set_in(1, 1'b0, 16'h0000);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    for (int s = 0; s < 2; s++) begin
      check("reset_cs", g_cs(s), 1'b1);
      check("reset_sclk", g_sclk(s), 1'b0);
      check("reset_mosi", g_mosi(s), 1'b0);
      check("reset_busy", g_busy(s), 1'b0);
      check("reset_done", g_done(s), 1'b0);
      check("reset_rx", g_rx(s), 16'h0000);
    end

    // ---- table-driven single transfers on the default instance ----
    for (int i = 0; i < 5; i++) begin
      loop_en   = vecs[i].loop;
      resp_word = vecs[i].resp;
      run_xfer(0, {8'h00, vecs[i].tx}, 0, 0, lat, rises, mosi_ok, timing_ok);
      check("vec_rx", bus0.RX_DATA, vecs[i].exp_rx);
      check("vec_latency", lat, 34);
      check("vec_rises", rises, 8);
      check("vec_mosi", mosi_ok, 1'b1);
      check("vec_timing", timing_ok, 1'b1);
    end
    loop_en = 1;

    // ---- START held high: three back-to-back transfers ----
    @(negedge CLK);
    set_in(0, 1'b1, {8'h00, words[0]});
    for (int i = 0; i < 3; i++) begin
      found = 0;
      for (int c = 0; c < 200 && !found; c++) begin
        @(negedge CLK);
        if (bus0.DONE) found = 1;
      end
      check("b2b_done", found, 1'b1);
      check("b2b_rx", bus0.RX_DATA, words[i]);
      check("b2b_cs_gap", bus0.CS, 1'b1);
      if (i < 2) begin
        bus0.TX_DATA = words[i+1];
        @(negedge CLK);
        check("b2b_cs_relow", bus0.CS, 1'b0);
        check("b2b_busy", bus0.BUSY, 1'b1);
        bus0.TX_DATA = ~words[i+1];
      end else begin
        bus0.START = 1'b0;
        @(negedge CLK);
        check("b2b_end_cs", bus0.CS, 1'b1);
        check("b2b_end_busy", bus0.BUSY, 1'b0);
      end
    end

    // ---- START pulsed again while busy ----
    run_xfer(0, 16'h0096, 10, 0, lat, rises, mosi_ok, timing_ok);
    check("ignore_rx", bus0.RX_DATA, 8'h96);
    check("ignore_latency", lat, 34);
    check("ignore_rises", rises, 8);
    repeat (4) @(negedge CLK);
    check("ignore_no_second", bus0.BUSY, 1'b0);
    check("ignore_cs_idle", bus0.CS, 1'b1);

    // ---- reset mid-transfer, then a normal transfer ----
    run_xfer(0, 16'h00C7, 0, 15, lat, rises, mosi_ok, timing_ok);
    run_xfer(0, 16'h003C, 0, 0, lat, rises, mosi_ok, timing_ok);
    check("post_rst_rx", bus0.RX_DATA, 8'h3C);
    check("post_rst_latency", lat, 34);

    // ---- WIDTH=16, CLK_DIV=1 instance ----
    run_xfer(1, 16'hBEEF, 0, 0, lat, rises, mosi_ok, timing_ok);
    check("w16_rx", bus1.RX_DATA, 16'hBEEF);
    check("w16_latency", lat, 33);
    check("w16_rises", rises, 16);
    check("w16_mosi", mosi_ok, 1'b1);
    check("w16_timing", timing_ok, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

SPI mode-0 initiator that drives the same four-wire bus our SPI responder blocks sit on. It turns a one-cycle START request on the system clock into a complete chip-select-framed transfer of WIDTH bits, MSB first. It returns the word shifted in on MISO with a one-cycle DONE strobe. It lives on the FPGA fabric side, driving an external or on-chip SPI responder.

## Interface
Parameters:
- WIDTH, 8, bits per transfer (≥1).
- CLK_DIV, 2, CLK cycles per SCLK half-period (≥1); SCLK frequency = f_CLK / (2·CLK_DIV).

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  transfer request; sampled only when BUSY=0.
- TX_DATA  input  WIDTH  word to send; captured on the edge that accepts START.
- RX_DATA  output  WIDTH  last received word; updated only when DONE asserts.
- BUSY  output  1  high from START acceptance until DONE.
- DONE  output  1  one-cycle strobe at end of transfer.
- SCLK  output  1  SPI clock, idle low.
- MOSI  output  1  serial data out.
- MISO  input  1  serial data in.
- CS  output  1  active-low chip select.

## Operation
- States: IDLE, LEAD, HIGH, LOW, FINISH.
- Reset (async, immediate): CS=1, SCLK=0, MOSI=0, BUSY=0, DONE=0, RX_DATA=0, state=IDLE, all counters 0.
- IDLE, START=1 at edge e0:
  - Load the TX shift register from TX_DATA.
  - Drive CS=0, MOSI=TX_DATA[WIDTH-1], BUSY=1.
  - Move to LEAD with SCLK=0.
- LEAD/LOW: after CLK_DIV cycles, drive SCLK=1 and go to HIGH. On that same edge, shift the current MISO value into the LSB of the RX shift register.
- HIGH: after CLK_DIV cycles, drive SCLK=0.
  - If fewer than WIDTH bits are done: shift the TX register left, present the next bit on MOSI, go to LOW.
  - After the WIDTH-th bit: hold MOSI and go to FINISH.
- FINISH: after CLK_DIV cycles, in a single edge:
  - CS=1, BUSY=0, DONE=1.
  - RX_DATA ← RX shift register.
  - MOSI=0.
  - Go to IDLE.
- DONE falls on the next edge.
- START while BUSY=1 is ignored; it is not queued.
- TX_DATA changes after acceptance do not affect the transfer in flight.
- START in the DONE cycle (BUSY=0) is accepted. CS therefore stays high for exactly 1 CLK cycle between back-to-back transfers.
- Bit counter width is clog2(WIDTH+1). Half-period counter width is clog2(CLK_DIV+1). Neither counter wraps within a transfer.
- Reset asserted mid-transfer aborts immediately to reset values. No DONE is produced and RX_DATA clears to 0.

## Timing
Relative to acceptance edge e0, with H = CLK_DIV:
- CS falls at e0.
- The rising SCLK edge for bit k (k=0..WIDTH-1, bit 0 = MSB) occurs at e0+(2k+1)·H.
- The falling SCLK edge for bit k occurs at e0+(2k+2)·H.
- MOSI changes only at e0 and at falling SCLK edges 0..WIDTH-2. It is stable for ≥H cycles either side of every rising edge.
- MISO is sampled at the CLK edge where SCLK rises. The responder must drive it during the preceding low phase.
- DONE, CS rise and BUSY fall all occur at e0+(2·WIDTH+1)·H. For defaults this is e0+34.
- SCLK is low whenever CS=1.
- Every SCLK high and low phase is exactly H cycles. The trailing CS hold after the last falling edge is also H cycles.

## Test plan
- Loopback (MOSI tied to MISO), defaults, TX_DATA=0xA5, START pulsed 1 cycle → RX_DATA=0xA5, DONE at e0+34, exactly 8 SCLK rising edges while CS=0.
- Bench responder shifts 0x3C out on MISO (changing on SCLK falling edges, MSB preset at CS fall), TX_DATA=0xFF → RX_DATA=0x3C, MOSI observed all ones at every rising edge.
- START held high for 3 transfers, TX_DATA=0x01, 0x80, 0x55 sequenced at each acceptance, loopback → three DONE strobes, RX values 0x01, 0x80, 0x55, CS high exactly 1 cycle between frames.
- START pulsed again at e0+10 while BUSY with different TX_DATA → ignored, single transfer, RX_DATA equals the first word.
- RST_N low at e0+15 → CS=1, SCLK=0, MOSI=0, BUSY=0, RX_DATA=0 asynchronously, no DONE. The next START completes normally.
- WIDTH=16, CLK_DIV=1, loopback TX_DATA=0xBEEF → RX_DATA=0xBEEF, DONE at e0+33, SCLK period 2 cycles.
